spi_xfer_seq: RTL and testbench

SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

---
 rtl/spi_xfer_seq.sv | 169 ++++++++++++++++
 tb/tb_spi_xfer_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_seq.sv
// Host-side sequencer for an SPI controller: a TX word FIFO with last-word flags,
// an RX FIFO, and a small FSM that launches one transfer per accepted go.
module spi_xfer_seq #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_wr,
    input  logic [31:0] tx_wdata,
    input  logic        tx_wlst,
    output logic        tx_full,
    output logic [4:0]  tx_cnt,
    input  logic        go,
    input  logic [1:0]  cfg_slv_sel,
    input  logic [1:0]  cfg_rd_len,
    input  logic        cfg_rd_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    input  logic        err_clr,
    input  logic        rx_rd,
    output logic [31:0] rx_rdata,
    output logic        rx_empty,
    output logic [4:0]  rx_cnt,
    output logic        ctl_strt,
    output logic [1:0]  ctl_slv_sel,
    output logic [1:0]  ctl_rd_len,
    output logic        ctl_rdata_en,
    output logic [31:0] ctl_rwdata,
    output logic        ctl_wd_empty,
    output logic        ctl_wd_lst,
    input  logic        ctl_wd_take,
    input  logic        ctl_rd_vld,
    input  logic [31:0] ctl_rd_data,
    input  logic        ctl_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] FULL_CNT = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, STRT, RUN, WAIT} state_t;

    state_t          state_q, state_d;
    logic [32:0]     tx_mem [DEPTH];
    logic [31:0]     rx_mem [DEPTH];
    logic [AW-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [4:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [1:0]      err_q, err_d;
    logic            done_q, done_d, ctl_strt_q, ctl_strt_d;
    logic [1:0]      slv_sel_q, slv_sel_d, rd_len_q, rd_len_d;
    logic            rdata_en_q, rdata_en_d;
    logic            tx_empty_w, rx_full_w;
    logic            tx_push, tx_pop, tx_ovf, rx_push, rx_pop, rx_ovf;
    logic [32:0]     tx_head;

    assign tx_head    = tx_mem[tx_rp_q];
    assign tx_empty_w = (tx_cnt_q == 5'd0);
    assign rx_full_w  = (rx_cnt_q == FULL_CNT);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign tx_pop  = (state_q == RUN) && ctl_wd_take && !tx_empty_w;
    assign tx_push = tx_wr && (!tx_full || tx_pop);
    assign tx_ovf  = tx_wr && !tx_push;
    assign rx_pop  = rx_rd && !rx_empty;
    assign rx_push = ctl_rd_vld && (!rx_full_w || rx_pop);
    assign rx_ovf  = ctl_rd_vld && !rx_push;

    always_comb begin
        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + 5'(tx_push) - 5'(tx_pop);
        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + 5'(rx_push) - 5'(rx_pop);
        // An overflow in the same cycle as a clear keeps its bit set.
        err_d[0] = tx_ovf | (err_q[0] & ~err_clr);
        err_d[1] = rx_ovf | (err_q[1] & ~err_clr);
    end

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        ctl_strt_d = (state_q == STRT);
        slv_sel_d  = slv_sel_q;
        rd_len_d   = rd_len_q;
        rdata_en_d = rdata_en_q;
        case (state_q)
            IDLE: begin
                if (go && (!tx_empty_w || cfg_rd_en)) begin
                    state_d    = STRT;
                    slv_sel_d  = cfg_slv_sel;
                    rd_len_d   = cfg_rd_len;
                    rdata_en_d = cfg_rd_en;
                end
            end
            STRT: state_d = RUN;
            RUN: begin
                // Early end from the controller leaves unsent words queued.
                if (ctl_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if ((tx_pop && tx_head[32]) || tx_empty_w) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ctl_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            ctl_strt_q <= 1'b0;
            slv_sel_q  <= '0;
            rd_len_q   <= '0;
            rdata_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            ctl_strt_q <= ctl_strt_d;
            slv_sel_q  <= slv_sel_d;
            rd_len_q   <= rd_len_d;
            rdata_en_q <= rdata_en_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= {tx_wlst, tx_wdata};
        if (rx_push) rx_mem[rx_wp_q] <= ctl_rd_data;
    end

    assign tx_full      = (tx_cnt_q == FULL_CNT);
    assign tx_cnt       = tx_cnt_q;
    assign rx_cnt       = rx_cnt_q;
    assign rx_empty     = (rx_cnt_q == 5'd0);
    assign rx_rdata     = rx_mem[rx_rp_q];
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign ctl_strt     = ctl_strt_q;
    assign ctl_slv_sel  = slv_sel_q;
    assign ctl_rd_len   = rd_len_q;
    assign ctl_rdata_en = rdata_en_q;
    assign ctl_rwdata   = tx_head[31:0];
    assign ctl_wd_lst   = tx_head[32];
    assign ctl_wd_empty = tx_empty_w;
endmodule

// File: tb/tb_spi_xfer_seq.sv
// Randomized scoreboard bench for spi_xfer_seq: queue-level model of both FIFOs,
// sticky errors and transfer start/done events, checked by a negedge monitor.
module tb_spi_xfer_seq;
    localparam int DEPTH = 8;

    logic        clk, rst;
    logic        tx_wr, tx_wlst, tx_full;
    logic [31:0] tx_wdata;
    logic [4:0]  tx_cnt, rx_cnt;
    logic        go, cfg_rd_en, busy, done, err_clr, rx_rd, rx_empty;
    logic [1:0]  cfg_slv_sel, cfg_rd_len, err;
    logic [31:0] rx_rdata, ctl_rwdata, ctl_rd_data;
    logic        ctl_strt, ctl_rdata_en, ctl_wd_empty, ctl_wd_lst;
    logic [1:0]  ctl_slv_sel, ctl_rd_len;
    logic        ctl_wd_take, ctl_rd_vld, ctl_done;

    spi_xfer_seq #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_wlst(tx_wlst), .tx_full(tx_full), .tx_cnt(tx_cnt),
        .go(go), .cfg_slv_sel(cfg_slv_sel), .cfg_rd_len(cfg_rd_len), .cfg_rd_en(cfg_rd_en),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr),
        .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_cnt(rx_cnt),
        .ctl_strt(ctl_strt), .ctl_slv_sel(ctl_slv_sel), .ctl_rd_len(ctl_rd_len),
        .ctl_rdata_en(ctl_rdata_en), .ctl_rwdata(ctl_rwdata), .ctl_wd_empty(ctl_wd_empty),
        .ctl_wd_lst(ctl_wd_lst), .ctl_wd_take(ctl_wd_take), .ctl_rd_vld(ctl_rd_vld),
        .ctl_rd_data(ctl_rd_data), .ctl_done(ctl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         c;
        logic [1:0] ss;
        logic [1:0] rl;
        logic       re;
    } strt_t;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] m_tx[$];
    logic [31:0] m_rx[$];
    logic [1:0]  m_err = 2'b00;
    bit          m_busy = 1'b0;
    strt_t       exp_strt[$];
    int          exp_done[$];
    strt_t       mon_e;
    int          mon_c;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic zero_inputs();
        tx_wr = 0; tx_wdata = '0; tx_wlst = 0; go = 0; err_clr = 0; rx_rd = 0;
        ctl_wd_take = 0; ctl_rd_vld = 0; ctl_rd_data = '0; ctl_done = 0;
    endtask

    task automatic chk_state();
        chk("tx_cnt", tx_cnt, m_tx.size());
        chk("rx_cnt", rx_cnt, m_rx.size());
        chk("tx_full", tx_full, m_tx.size() == DEPTH);
        chk("ctl_wd_empty", ctl_wd_empty, m_tx.size() == 0);
        chk("rx_empty", rx_empty, m_rx.size() == 0);
        chk("err", err, m_err);
        chk("busy", busy, m_busy);
    endtask

    // One clock of stimulus: predict the edge's effect from the current inputs,
    // let the edge happen, then commit the model and compare visible state.
    task automatic step();
        bit          tp, ta, rp, ra, old_busy;
        logic [32:0] tw;
        logic [31:0] rw;
        logic [1:0]  ne;
        tp = ctl_wd_take && (m_tx.size() > 0);
        ta = tx_wr && ((m_tx.size() < DEPTH) || tp);
        tw = {tx_wlst, tx_wdata};
        rp = rx_rd && (m_rx.size() > 0);
        ra = ctl_rd_vld && ((m_rx.size() < DEPTH) || rp);
        rw = ctl_rd_data;
        ne[0] = (tx_wr && !ta) || (m_err[0] && !err_clr);
        ne[1] = (ctl_rd_vld && !ra) || (m_err[1] && !err_clr);
        old_busy = m_busy;
        if (go && !old_busy && ((m_tx.size() > 0) || cfg_rd_en)) begin
            exp_strt.push_back('{cyc + 2, cfg_slv_sel, cfg_rd_len, cfg_rd_en});
            m_busy = 1'b1;
        end
        if (ctl_done && old_busy) begin
            exp_done.push_back(cyc + 1);
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        if (ta) m_tx.push_back(tw);
        if (ra) m_rx.push_back(rw);
        m_err = ne;
        zero_inputs();
        chk_state();
    endtask

    task automatic do_reset();
        rst = 1; tx_wr = 1; tx_wdata = $urandom; go = 1; ctl_rd_vld = 1; ctl_done = 1;
        ctl_wd_take = 1; cfg_rd_en = 1;
        @(posedge clk);
        #1;
        rst = 0; cfg_rd_en = 0;
        zero_inputs();
        m_tx.delete(); m_rx.delete(); m_err = 2'b00; m_busy = 1'b0;
        chk_state();
        chk("rst_ctl_strt", ctl_strt, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg", {ctl_slv_sel, ctl_rd_len, ctl_rdata_en}, 5'b0);
        step();
        step();
    endtask

    task automatic push_word(input logic [31:0] d, input bit l);
        tx_wr = 1; tx_wdata = d; tx_wlst = l;
        step();
    endtask

    task automatic start_xfer();
        go = 1;
        step();
        step();
    endtask

    task automatic take_all();
        int budget = 200;
        bit stop = 0;
        while (!stop && (m_tx.size() > 0) && (budget > 0)) begin
            budget--;
            if ($urandom_range(0, 2) != 0) begin
                stop = m_tx[0][32];
                ctl_wd_take = 1;
            end
            step();
        end
        chk("take_budget_exhausted", budget == 0, 0);
    endtask

    task automatic rx_words(input int n);
        repeat (n) begin
            ctl_rd_vld = 1; ctl_rd_data = $urandom;
            step();
        end
    endtask

    task automatic end_xfer();
        ctl_done = 1;
        step();
        step();
    endtask

    task automatic drain_rx();
        int budget = 100;
        while ((m_rx.size() > 0) && (budget > 0)) begin
            budget--;
            rx_rd = ($urandom_range(0, 1) == 1);
            step();
        end
        chk("drain_budget_exhausted", budget == 0, 0);
    endtask

    // Monitor: compares every word handed over and every start/done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (ctl_strt) begin
                if (exp_strt.size() == 0) chk("strt_unexpected", ctl_strt, 0);
                else begin
                    mon_e = exp_strt.pop_front();
                    chk("strt_cycle", cyc, mon_e.c);
                    chk("strt_cfg", {ctl_slv_sel, ctl_rd_len, ctl_rdata_en}, {mon_e.ss, mon_e.rl, mon_e.re});
                    chk("strt_wd_empty", ctl_wd_empty, m_tx.size() == 0);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("done_unexpected", done, 0);
                else begin
                    mon_c = exp_done.pop_front();
                    chk("done_cycle", cyc, mon_c);
                end
            end
            if (ctl_wd_take) begin
                if (m_tx.size() == 0) chk("take_on_empty", ctl_wd_empty, 1);
                else chk("tx_word", {ctl_wd_lst, ctl_rwdata}, m_tx.pop_front());
            end
            if (rx_rd) begin
                chk("rx_empty_at_rd", rx_empty, m_rx.size() == 0);
                if (m_rx.size() > 0) chk("rx_word", rx_rdata, m_rx.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; cfg_slv_sel = 0; cfg_rd_len = 0; cfg_rd_en = 0;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // go with nothing to do is ignored; rx_rd on empty is harmless
        go = 1; step();
        rx_rd = 1; step();

        // three-word write transfer
        cfg_slv_sel = 0; cfg_rd_len = 1; cfg_rd_en = 0;
        push_word(32'hAAAAAAAA, 0);
        push_word(32'h1, 0);
        push_word(32'h2, 1);
        start_xfer();
        take_all();
        step();
        chk("wait_busy", busy, 1);
        end_xfer();
        chk("xfer1_tx_cnt", tx_cnt, 0);

        // read-only transfer with empty TX
        cfg_slv_sel = 2; cfg_rd_len = 3; cfg_rd_en = 1;
        start_xfer();
        rx_words(4);
        chk("read_rx_cnt", rx_cnt, 4);
        end_xfer();
        drain_rx();

        // TX overflow, sticky error, clear, clear-vs-event, push+pop at full
        cfg_rd_en = 0; cfg_slv_sel = 1;
        for (int i = 0; i < DEPTH; i++) push_word($urandom, 0);
        push_word(32'hDEADBEEF, 1);
        chk("tx_ovf_err", err, 2'b01);
        err_clr = 1; step();
        chk("err_cleared", err, 2'b00);
        tx_wr = 1; tx_wdata = $urandom; err_clr = 1; step();
        chk("err_clr_vs_event", err, 2'b01);
        err_clr = 1; step();
        start_xfer();
        tx_wr = 1; tx_wdata = 32'h5A5A0001; tx_wlst = 1; ctl_wd_take = 1; step();
        chk("full_push_pop_cnt", tx_cnt, DEPTH);
        take_all();
        end_xfer();

        // RX overflow and go while busy
        rx_words(DEPTH);
        ctl_rd_vld = 1; ctl_rd_data = 32'hBAD0BAD0; step();
        chk("rx_ovf_err", err, 2'b10);
        chk("rx_ovf_cnt", rx_cnt, DEPTH);
        ctl_rd_vld = 1; ctl_rd_data = $urandom; rx_rd = 1; step();
        err_clr = 1; step();
        cfg_slv_sel = 3; cfg_rd_len = 2;
        push_word($urandom, 0);
        push_word($urandom, 1);
        start_xfer();
        go = 1; step();
        take_all();
        go = 1; step();
        end_xfer();
        drain_rx();

        // reset in RUN with words queued, then early end with words retained
        cfg_slv_sel = 1; cfg_rd_len = 0;
        for (int i = 0; i < 4; i++) push_word($urandom, i == 3);
        start_xfer();
        ctl_wd_take = 1; step();
        ctl_wd_take = 1; step();
        chk("pre_rst_cnt", tx_cnt, 2);
        do_reset();
        chk("post_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) push_word($urandom, i == 2);
        start_xfer();
        ctl_wd_take = 1; step();
        end_xfer();
        chk("early_end_retained", tx_cnt, 2);
        start_xfer();
        take_all();
        end_xfer();

        // randomized transfers
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, DEPTH);
            cfg_slv_sel = 2'($urandom);
            cfg_rd_len = 2'($urandom);
            cfg_rd_en = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) push_word($urandom, i == n - 1);
            start_xfer();
            take_all();
            rx_words($urandom_range(0, DEPTH));
            end_xfer();
            drain_rx();
        end

        repeat (4) step();
        chk("strt_pending", exp_strt.size(), 0);
        chk("done_pending", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
